// File: rtl/pnc_pkg.sv
// Shared definitions for the PNC packet decoder: header field layout,
// address-control code layout, FSM states and the default timeout.
package pnc_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  localparam int BEAT_W        = 32;
  localparam int HDR_PARAM_BIT = 31;
  localparam int HDR_RC_BIT    = 30;
  localparam int HDR_TGT_LSB   = 28;
  localparam int HDR_TGT_W     = 2;
  localparam int HDR_NADDR_LSB = 20;
  localparam int HDR_NADDR_W   = 8;
  localparam int PAYLOAD_LSB   = 0;
  localparam int PAYLOAD_W     = 16;

  localparam int CTL_W         = 4;
  localparam int CTL_PARAM_BIT = 3;
  localparam int CTL_RC_BIT    = 2;
  localparam int CTL_TGT_LSB   = 0;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_PARAM_DATA = 1'b1
  } state_e;

  function automatic logic [CTL_W-1:0] make_ctl(input logic param,
                                                input logic rc,
                                                input logic [HDR_TGT_W-1:0] tgt);
    logic [CTL_W-1:0] c;
    c                            = '0;
    c[CTL_PARAM_BIT]             = param;
    c[CTL_RC_BIT]                = rc;
    c[CTL_TGT_LSB +: HDR_TGT_W]  = tgt;
    return c;
  endfunction

endpackage

// File: rtl/pnc_packet_decoder.sv
// Decodes spike beats and two-beat parameter packets into an address-control
// code, neuron address and payload, with a timeout on a missing data beat.
module pnc_packet_decoder
  import pnc_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [BEAT_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [CTL_W-1:0]       oADDR_ctl,
  output logic [HDR_NADDR_W-1:0] o_addr,
  output logic [PAYLOAD_W-1:0]   o_data,
  output logic                   o_valid,
  input  logic                   out_ready,
  input  logic                   err_clr,
  output logic                   err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [CTL_W-1:0]       ctl_q, ctl_d;
  logic [HDR_NADDR_W-1:0] addr_q, addr_d;
  logic [PAYLOAD_W-1:0]   data_q, data_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CTL_W-1:0]       hdr_ctl_q, hdr_ctl_d;
  logic [HDR_NADDR_W-1:0] hdr_addr_q, hdr_addr_d;

  logic                   free;
  logic                   take;
  logic                   load;
  logic                   timeout;
  logic [CNT_W-1:0]       cnt_inc;
  logic [HDR_NADDR_W-1:0] beat_naddr;
  logic [PAYLOAD_W-1:0]   beat_payload;
  logic                   unused_bits;

  assign free         = !valid_q || out_ready;
  assign in_ready     = free;
  assign take         = in_valid && in_ready;
  assign cnt_inc      = cnt_q + 1'b1;
  assign beat_naddr   = in_data[HDR_NADDR_LSB +: HDR_NADDR_W];
  assign beat_payload = in_data[PAYLOAD_LSB +: PAYLOAD_W];
  assign unused_bits  = ^in_data[HDR_NADDR_LSB-1:PAYLOAD_LSB+PAYLOAD_W];

  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    hdr_ctl_d  = hdr_ctl_q;
    hdr_addr_d = hdr_addr_q;
    load       = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (in_data[HDR_PARAM_BIT]) begin
            // Parameter packets always carry RC=0; TGT comes from the header.
            hdr_ctl_d  = make_ctl(1'b1, 1'b0, in_data[HDR_TGT_LSB +: HDR_TGT_W]);
            hdr_addr_d = beat_naddr;
            cnt_d      = '0;
            state_d    = ST_PARAM_DATA;
          end else begin
            ctl_d  = make_ctl(1'b0, in_data[HDR_RC_BIT], '0);
            addr_d = beat_naddr;
            data_d = beat_payload;
            load   = 1'b1;
          end
        end
      end
      ST_PARAM_DATA: begin
        // An accepted data beat takes priority over an expiring timeout.
        if (take) begin
          ctl_d   = hdr_ctl_q;
          addr_d  = hdr_addr_q;
          data_d  = beat_payload;
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_inc == CNT_LIMIT) begin
          timeout = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      ctl_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      hdr_ctl_q  <= '0;
      hdr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ctl_q      <= ctl_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      hdr_ctl_q  <= hdr_ctl_d;
      hdr_addr_q <= hdr_addr_d;
    end
  end

  assign o_valid   = valid_q;
  assign oADDR_ctl = ctl_q;
  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pnc_packet_decoder.sv
// Bench for pnc_packet_decoder: directed vector table, reset corner sequence,
// then randomized traffic against a packet-level reference model.
module tb_pnc_packet_decoder;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  oADDR_ctl;
  logic [7:0]  o_addr;
  logic [15:0] o_data;
  logic        o_valid;
  logic        out_ready;
  logic        err_clr;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pnc_packet_decoder #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .oADDR_ctl (oADDR_ctl),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err       (err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic clr);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    err_clr   = clr;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                         input logic [7:0] a, input logic [15:0] d, input logic e);
    chk({tag, "_valid"}, o_valid, v);
    chk({tag, "_ctl"}, oADDR_ctl, c);
    chk({tag, "_addr"}, o_addr, a);
    chk({tag, "_data"}, o_data, d);
    chk({tag, "_err"}, err, e);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        clr;
    logic        erdy;
    logic        ev;
    logic [3:0]  ectl;
    logic [7:0]  eaddr;
    logic [15:0] edata;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic clr, input logic erdy, input logic ev,
                              input logic [3:0] ectl, input logic [7:0] eaddr,
                              input logic [15:0] edata, input logic eerr);
    vec_t r;
    r.iv = iv; r.id = id; r.ordy = ordy; r.clr = clr; r.erdy = erdy;
    r.ev = ev; r.ectl = ectl; r.eaddr = eaddr; r.edata = edata; r.eerr = eerr;
    return r;
  endfunction

  // Reference model: decoded packet on the outputs, pending header, idle count.
  bit       m_valid, m_err, m_pend;
  bit [3:0] m_ctl, m_hctl;
  bit [7:0] m_addr, m_haddr;
  bit [15:0] m_data;
  int       m_idle;
  int       n_timeouts = 0;
  int       n_xfers = 0;

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_pend = 0; m_ctl = 0; m_hctl = 0;
    m_addr = 0; m_haddr = 0; m_data = 0; m_idle = 0;
  endtask

  task automatic model_clock();
    bit take, cons, loaded, tmo;
    take   = in_valid && (!m_valid || out_ready);
    cons   = m_valid && out_ready;
    loaded = 0;
    tmo    = 0;
    if (cons) begin
      n_xfers++;
      $display("xfer %0d: ctl=%h addr=%h data=%h", n_xfers, m_ctl, m_addr, m_data);
    end
    if (!m_pend) begin
      if (take && in_data[31]) begin
        m_pend  = 1;
        m_hctl  = {2'b10, in_data[29:28]};
        m_haddr = in_data[27:20];
        m_idle  = 0;
      end else if (take) begin
        loaded = 1;
        m_ctl  = {1'b0, in_data[30], 2'b00};
        m_addr = in_data[27:20];
        m_data = in_data[15:0];
      end
    end else if (take) begin
      loaded = 1;
      m_ctl  = m_hctl;
      m_addr = m_haddr;
      m_data = in_data[15:0];
      m_pend = 0;
    end else begin
      m_idle++;
      if (m_idle == int'(TO)) begin
        m_pend = 0;
        tmo    = 1;
        n_timeouts++;
      end
    end
    if (loaded) m_valid = 1;
    else if (cons) m_valid = 0;
    if (tmo) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 0, 0);

    vecs.push_back(mk(1, 32'h4120_0ABC, 0, 0, 1, 1, 4'h4, 8'h12, 16'h0ABC, 0));
    vecs.push_back(mk(1, 32'h0F00_1234, 0, 0, 0, 1, 4'h4, 8'h12, 16'h0ABC, 0));
    vecs.push_back(mk(1, 32'h0F00_1234, 0, 0, 0, 1, 4'h4, 8'h12, 16'h0ABC, 0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0, 4'h4, 8'h12, 16'h0ABC, 0));
    vecs.push_back(mk(1, 32'hA340_0000, 1, 0, 1, 0, 4'h4, 8'h12, 16'h0ABC, 0));
    vecs.push_back(mk(1, 32'h0000_5A5A, 1, 0, 1, 1, 4'hA, 8'h34, 16'h5A5A, 0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0, 4'hA, 8'h34, 16'h5A5A, 0));
    vecs.push_back(mk(1, 32'h0010_0001, 1, 0, 1, 1, 4'h0, 8'h01, 16'h0001, 0));
    vecs.push_back(mk(1, 32'h4020_0002, 1, 0, 1, 1, 4'h4, 8'h02, 16'h0002, 0));
    vecs.push_back(mk(1, 32'h0030_0003, 1, 0, 1, 1, 4'h0, 8'h03, 16'h0003, 0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 0));
    // Header with no data: error after the fourth idle cycle.
    vecs.push_back(mk(1, 32'h8550_0000, 1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 1));
    // Second timeout coinciding with err_clr keeps err set.
    vecs.push_back(mk(1, 32'h8770_0000, 1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 1));
    vecs.push_back(mk(0, 32'h0,         1, 1, 1, 0, 4'h0, 8'h03, 16'h0003, 1));
    vecs.push_back(mk(0, 32'h0,         1, 1, 1, 0, 4'h0, 8'h03, 16'h0003, 0));
    // Data beat on the fourth cycle wins over the timeout.
    vecs.push_back(mk(1, 32'h9660_0000, 1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, 4'h0, 8'h03, 16'h0003, 0));
    vecs.push_back(mk(1, 32'h0000_BEEF, 1, 0, 1, 1, 4'h9, 8'h66, 16'hBEEF, 0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0, 4'h9, 8'h66, 16'hBEEF, 0));

    #12;
    chk_out("reset", 0, 4'h0, 8'h00, 16'h0000, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), in_ready, vecs[i].erdy);
      @(posedge clk); #1;
      $display("vec %0d: in=%h iv=%0b ordy=%0b clr=%0b -> v=%0b ctl=%h addr=%h data=%h err=%0b",
               i, vecs[i].id, vecs[i].iv, vecs[i].ordy, vecs[i].clr,
               o_valid, oADDR_ctl, o_addr, o_data, err);
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ectl, vecs[i].eaddr,
              vecs[i].edata, vecs[i].eerr);
    end

    // Reset in the middle of a parameter packet.
    drive(1, 32'h4AB0_1111, 1, 0);
    @(posedge clk); #1;
    chk_out("mid_spike", 1, 4'h4, 8'hAB, 16'h1111, 0);
    drive(1, 32'hB120_0000, 1, 0);
    @(posedge clk); #1;
    chk_out("mid_header", 0, 4'h4, 8'hAB, 16'h1111, 0);
    drive(0, 32'h0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_reset", 0, 4'h0, 8'h00, 16'h0000, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", in_ready, 1);
    @(posedge clk); #1;
    drive(1, 32'h0000_2222, 1, 0);
    @(posedge clk); #1;
    $display("post-reset beat: ctl=%h addr=%h data=%h", oADDR_ctl, o_addr, o_data);
    chk_out("post_rst_beat", 1, 4'h0, 8'h00, 16'h2222, 0);
    drive(1, 32'h4120_0ABC, 1, 0);
    @(posedge clk); #1;
    $display("post-reset spike: ctl=%h addr=%h data=%h", oADDR_ctl, o_addr, o_data);
    chk_out("post_rst_spike", 1, 4'h4, 8'h12, 16'h0ABC, 0);
    drive(0, 32'h0, 1, 0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [31:0] d;
      int busy;
      busy = ((cyc / 200) % 2 == 0) ? 70 : 25;
      d = $urandom;
      d[31] = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 99) < busy, d, $urandom_range(0, 99) < 70,
            $urandom_range(0, 19) == 0);
      @(negedge clk);
      chk("rnd_ready", in_ready, !m_valid || out_ready);
      chk_out("rnd", m_valid, m_ctl, m_addr, m_data, m_err);
      @(posedge clk);
      model_clock();
      #1;
    end
    $display("random phase: %0d transfers, %0d timeouts", n_xfers, n_timeouts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
